// File: rtl/alu_mul_seq_pkg.sv
// Shared types for the multiply sequencer and the ALU it borrows.
// Holds the ALU function codes, the sequencer state encoding and iteration count.
package alu_mul_seq_pkg;

    localparam int MUL_W     = 16;
    localparam int MUL_ITERS = 16;
    localparam int CNT_W     = $clog2(MUL_ITERS + 1);

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SL   = 3'd5,
        ALU_SR   = 3'd6,
        ALU_PASS = 3'd7
    } alu_func_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        STEP = 3'd1,
        ADD  = 3'd2,
        SHL  = 3'd3,
        SHR  = 3'd4,
        DONE = 3'd5
    } mul_state_e;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Operand and product handshake channels between execute and the multiply sequencer.
// Execute drives the master side; the sequencer is the slave.
interface alu_mul_seq_if;
    import alu_mul_seq_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [MUL_W-1:0] in_a;
    logic [MUL_W-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [MUL_W-1:0] out_prod;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_prod
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_prod
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier that owns no arithmetic: every add and shift is one
// request to the shared ALU, which only takes effect in cycles where alu_gnt is high.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    alu_mul_seq_if.slave     bus,
    output logic             busy,
    input  logic             alu_gnt,
    output alu_func_e        alu_func,
    output logic [MUL_W-1:0] alu_a,
    output logic [MUL_W-1:0] alu_b,
    input  logic [MUL_W-1:0] alu_res
);

    mul_state_e       state_q,  state_d;
    logic [MUL_W-1:0] prod_q,   prod_d;
    logic [MUL_W-1:0] mcand_q,  mcand_d;
    logic [MUL_W-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] count_q,  count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
        end
    end

    // ALU requests depend on state alone so the arbiter never sees a loop through alu_gnt.
    always_comb begin
        state_d  = state_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        alu_func = ALU_ADD;
        alu_a    = '0;
        alu_b    = '0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_d  = bus.in_a;
                    mplier_d = bus.in_b;
                    prod_d   = '0;
                    count_d  = '0;
                    state_d  = STEP;
                end
            end
            STEP: begin
                if ((EARLY_EXIT && (mplier_q == '0)) || (count_q == CNT_W'(MUL_ITERS))) begin
                    state_d = DONE;
                end else if (mplier_q[0]) begin
                    state_d = ADD;
                end else begin
                    state_d = SHL;
                end
            end
            ADD: begin
                alu_func = ALU_ADD;
                alu_a    = prod_q;
                alu_b    = mcand_q;
                if (alu_gnt) begin
                    prod_d  = alu_res;
                    state_d = SHL;
                end
            end
            SHL: begin
                alu_func = ALU_SL;
                alu_a    = mcand_q;
                alu_b    = MUL_W'(1);
                if (alu_gnt) begin
                    mcand_d = alu_res;
                    state_d = SHR;
                end
            end
            SHR: begin
                alu_func = ALU_SR;
                alu_a    = mplier_q;
                alu_b    = MUL_W'(1);
                if (alu_gnt) begin
                    mplier_d = alu_res;
                    count_d  = count_q + 1'b1;
                    state_d  = STEP;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_prod  = prod_q;
    assign busy          = (state_q != IDLE);

endmodule
